// File: rtl/axis_bram_reader.sv
// rtl/axis_bram_reader.sv - streams BRAM words 0..end_reg over AXI4-Stream, once or continuously
module axis_bram_reader #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int BRAM_DATA_WIDTH  = 32,
    parameter int BRAM_ADDR_WIDTH  = 10
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [BRAM_ADDR_WIDTH-1:0]  cfg_data,
    input  logic                        cfg_cont,
    input  logic                        cfg_start,
    output logic [BRAM_ADDR_WIDTH-1:0]  sts_data,
    output logic                        sts_busy,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        b_bram_clk,
    output logic                        b_bram_rst,
    output logic                        b_bram_en,
    output logic [BRAM_ADDR_WIDTH-1:0]  b_bram_addr,
    input  logic [BRAM_DATA_WIDTH-1:0]  b_bram_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                               state, state_nxt;
    logic [BRAM_ADDR_WIDTH-1:0]           addr, end_reg;
    logic                                 inflight, inflight_last;
    logic [1:0][BRAM_DATA_WIDTH-1:0]      buf_data;
    logic [1:0]                           buf_last;
    logic                                 rd_ptr, wr_ptr;
    logic [1:0]                           buf_count;
    logic [2:0]                           occupancy;
    logic                                 pop, push, issue, at_end;

    assign pop       = m_axis_tvalid & m_axis_tready;
    assign push      = inflight;
    assign at_end    = (addr == end_reg);
    // Buffered plus in-flight words as they will stand after this cycle's pop.
    assign occupancy = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = (state == RUN) && (occupancy < 3'd2);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg_start) state_nxt = RUN;
            RUN:     if (issue && at_end && !cfg_cont) state_nxt = DRAIN;
            // Leave as the final word is accepted so busy drops the very next cycle.
            DRAIN:   if (!inflight && (buf_count == {1'b0, pop})) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state         <= IDLE;
            addr          <= '0;
            end_reg       <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            buf_data      <= '0;
            buf_last      <= '0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            buf_count     <= 2'd0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && cfg_start) begin
                addr    <= '0;
                end_reg <= cfg_data;
            end else if (issue) begin
                addr <= at_end ? '0 : addr + 1'b1;
            end
            inflight      <= issue;
            inflight_last <= issue & at_end;
            if (push) begin
                buf_data[wr_ptr] <= b_bram_rdata;
                buf_last[wr_ptr] <= inflight_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   buf_count <= buf_count + 2'd1;
                2'b01:   buf_count <= buf_count - 2'd1;
                default: ;
            endcase
        end
    end

    assign m_axis_tvalid = (buf_count != 2'd0);
    assign m_axis_tdata  = buf_data[rd_ptr];
    assign m_axis_tlast  = buf_last[rd_ptr];
    assign b_bram_clk    = aclk;
    assign b_bram_rst    = ~aresetn;
    assign b_bram_en     = issue;
    assign b_bram_addr   = addr;
    assign sts_data      = addr;
    assign sts_busy      = (state != IDLE);

endmodule

// File: tb/tb_axis_bram_reader.sv
// tb/tb_axis_bram_reader.sv - randomized self-checking bench for axis_bram_reader
module tb_axis_bram_reader;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [9:0]  cfg_data = '0;
    logic        cfg_cont = 1'b0;
    logic        cfg_start = 1'b0;
    logic [9:0]  sts_data;
    logic        sts_busy;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic        b_bram_clk;
    logic        b_bram_rst;
    logic        b_bram_en;
    logic [9:0]  b_bram_addr;
    logic [31:0] b_bram_rdata = '0;

    logic [31:0] mem [1024];

    int total = 0;
    int bad = 0;

    logic [31:0] got_data [$];
    logic        got_last [$];
    int          got_cyc [$];
    int          cyc = 0;
    int          issued_total = 0;
    int          outst = 0;
    int          outst_err = 0;
    int          stab_err = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    axis_bram_reader #(
        .AXIS_TDATA_WIDTH(32),
        .BRAM_DATA_WIDTH(32),
        .BRAM_ADDR_WIDTH(10)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .cfg_data(cfg_data),
        .cfg_cont(cfg_cont),
        .cfg_start(cfg_start),
        .sts_data(sts_data),
        .sts_busy(sts_busy),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .b_bram_clk(b_bram_clk),
        .b_bram_rst(b_bram_rst),
        .b_bram_en(b_bram_en),
        .b_bram_addr(b_bram_addr),
        .b_bram_rdata(b_bram_rdata)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (b_bram_en) b_bram_rdata <= mem[b_bram_addr];
    end

    // Observer: accepted words, held-data violations and outstanding-read count.
    always @(negedge aclk) begin
        if (!aresetn) begin
            outst      <= 0;
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last))
                stab_err <= stab_err + 1;
            if (b_bram_en) issued_total <= issued_total + 1;
            if (m_axis_tvalid && m_axis_tready) begin
                got_data.push_back(m_axis_tdata);
                got_last.push_back(m_axis_tlast);
                got_cyc.push_back(cyc);
            end
            outst <= outst + (b_bram_en ? 1 : 0) - ((m_axis_tvalid && m_axis_tready) ? 1 : 0);
            if (outst + (b_bram_en ? 1 : 0) - ((m_axis_tvalid && m_axis_tready) ? 1 : 0) > 2)
                outst_err <= outst_err + 1;
            prev_stall <= m_axis_tvalid && !m_axis_tready;
            prev_data  <= m_axis_tdata;
            prev_last  <= m_axis_tlast;
        end
        cyc <= cyc + 1;
    end

    function automatic logic [31:0] word_at(input int a);
        return mem[a[9:0]];
    endfunction

    task automatic wait_words(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (got_data.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge aclk); #1;
        end
        if (got_data.size() >= n) ok = 1'b1;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!sts_busy) begin
                ok = 1'b1;
                break;
            end
            @(posedge aclk); #1;
        end
        if (!sts_busy) ok = 1'b1;
    endtask

    task automatic start_pass(input int d, input bit cont, output int c0);
        @(posedge aclk); #1;
        cfg_data  = d[9:0];
        cfg_cont  = cont;
        cfg_start = 1'b1;
        c0 = cyc;
        @(posedge aclk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        total++; if (b_bram_rst !== 1'b1) begin bad++; $display("FAIL rst_bram_rst: got %b want 1", b_bram_rst); end
        total++; if (b_bram_clk !== aclk) begin bad++; $display("FAIL rst_bram_clk: got %b want %b", b_bram_clk, aclk); end
        aresetn = 1'b1;
        @(posedge aclk); #1;
        total++; if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin bad++; $display("FAIL rst_stream: tvalid=%b tlast=%b want 0 0", m_axis_tvalid, m_axis_tlast); end
        total++; if (m_axis_tdata !== 32'd0) begin bad++; $display("FAIL rst_tdata: got %0h want 0", m_axis_tdata); end
        total++; if (b_bram_en !== 1'b0 || b_bram_addr !== 10'd0) begin bad++; $display("FAIL rst_bram: en=%b addr=%0d want 0 0", b_bram_en, b_bram_addr); end
        total++; if (sts_data !== 10'd0 || sts_busy !== 1'b0) begin bad++; $display("FAIL rst_sts: data=%0d busy=%b want 0 0", sts_data, sts_busy); end
        total++; if (b_bram_rst !== 1'b0) begin bad++; $display("FAIL rst_release: bram_rst=%b want 0", b_bram_rst); end
    endtask

    task automatic test_single_pass();
        int base, c0;
        bit ok;
        m_axis_tready = 1'b1;
        base = got_data.size();
        start_pass(7, 1'b0, c0);
        total++; if (b_bram_en !== 1'b1 || b_bram_addr !== 10'd0) begin bad++; $display("FAIL sp_first_issue: en=%b addr=%0d want 1 0", b_bram_en, b_bram_addr); end
        wait_words(base + 8, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL sp_timeout: got %0d words want 8", got_data.size() - base); end
        if (ok) begin
            total++; if (got_cyc[base] !== c0 + 3) begin bad++; $display("FAIL sp_latency: first word cycle %0d want %0d", got_cyc[base], c0 + 3); end
            for (int i = 0; i < 8; i++) begin
                total++;
                if (got_data[base+i] !== word_at(i) || got_last[base+i] !== (i == 7) || (i > 0 && got_cyc[base+i] !== got_cyc[base+i-1] + 1)) begin
                    bad++; $display("FAIL sp_word%0d: data=%0d last=%b want %0d %b (gap or value)", i, got_data[base+i], got_last[base+i], word_at(i), (i == 7));
                end
            end
            total++; if (sts_busy !== 1'b0) begin bad++; $display("FAIL sp_busy_fall: busy=%b want 0 in cycle after last word", sts_busy); end
            total++; if (sts_data !== 10'd0) begin bad++; $display("FAIL sp_sts_data: got %0d want 0", sts_data); end
        end
        repeat (5) @(posedge aclk);
        #1;
        total++; if (got_data.size() !== base + 8) begin bad++; $display("FAIL sp_extra: got %0d words want 8", got_data.size() - base); end
    endtask

    task automatic run_random_pass(input int d, input string tag);
        int base, c0, s0, o0;
        bit ok;
        base = got_data.size();
        s0 = stab_err;
        o0 = outst_err;
        m_axis_tready = 1'($urandom_range(1, 0));
        start_pass(d, 1'b0, c0);
        for (int i = 0; i < 40 * (d + 2) && got_data.size() < base + d + 1; i++) begin
            m_axis_tready = 1'($urandom_range(1, 0));
            @(posedge aclk); #1;
        end
        m_axis_tready = 1'b1;
        wait_idle(20, ok);
        total++; if (!ok || got_data.size() !== base + d + 1) begin bad++; $display("FAIL %s_len: got %0d words idle=%b want %0d", tag, got_data.size() - base, ok, d + 1); end
        for (int i = 0; i <= d && base + i < got_data.size(); i++) begin
            total++;
            if (got_data[base+i] !== word_at(i) || got_last[base+i] !== (i == d)) begin
                bad++; $display("FAIL %s_word%0d: data=%0h last=%b want %0h %b", tag, i, got_data[base+i], got_last[base+i], word_at(i), (i == d));
            end
        end
        total++; if (stab_err !== s0) begin bad++; $display("FAIL %s_stable: %0d held-data changes want 0", tag, stab_err - s0); end
        total++; if (outst_err !== o0) begin bad++; $display("FAIL %s_outstanding: %0d cycles over 2 reads want 0", tag, outst_err - o0); end
    endtask

    task automatic test_backpressure();
        run_random_pass(7, "bp");
    endtask

    task automatic test_random_size();
        for (int k = 0; k < 3; k++) run_random_pass(int'($urandom_range(40, 0)), "rnd");
    endtask

    task automatic test_continuous();
        int base, c0, iss0, k, exp_n, n;
        bit ok;
        m_axis_tready = 1'b1;
        base = got_data.size();
        start_pass(3, 1'b1, c0);
        iss0 = issued_total;
        wait_words(base + 12, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL cont_timeout: got %0d words want 12", got_data.size() - base); end
        repeat ($urandom_range(3, 0)) @(posedge aclk);
        #1;
        k = issued_total - iss0;
        exp_n = (k / 4 + 1) * 4;
        cfg_cont = 1'b0;
        wait_idle(60, ok);
        n = got_data.size() - base;
        total++; if (!ok || n !== exp_n) begin bad++; $display("FAIL cont_len: got %0d words idle=%b want %0d", n, ok, exp_n); end
        for (int i = 0; i < n; i++) begin
            total++;
            if (got_data[base+i] !== word_at(i % 4) || got_last[base+i] !== (i % 4 == 3) || (i > 0 && got_cyc[base+i] !== got_cyc[base+i-1] + 1)) begin
                bad++; $display("FAIL cont_word%0d: data=%0d last=%b want %0d %b (gap or value)", i, got_data[base+i], got_last[base+i], word_at(i % 4), (i % 4 == 3));
            end
        end
    endtask

    task automatic test_edge_size();
        int base, c0, n;
        bit ok;
        m_axis_tready = 1'b1;
        base = got_data.size();
        start_pass(0, 1'b1, c0);
        wait_words(base + 6, 30, ok);
        cfg_cont = 1'b0;
        wait_idle(20, ok);
        n = got_data.size() - base;
        total++; if (!ok || n < 6) begin bad++; $display("FAIL edge_len: got %0d words idle=%b want >=6", n, ok); end
        if (n > 0) begin
            total++; if (got_cyc[base] !== c0 + 3) begin bad++; $display("FAIL edge_latency: cycle %0d want %0d", got_cyc[base], c0 + 3); end
        end
        for (int i = 0; i < n; i++) begin
            total++;
            if (got_data[base+i] !== word_at(0) || got_last[base+i] !== 1'b1 || (i > 0 && got_cyc[base+i] !== got_cyc[base+i-1] + 1)) begin
                bad++; $display("FAIL edge_word%0d: data=%0d last=%b want %0d 1 (gap or value)", i, got_data[base+i], got_last[base+i], word_at(0));
            end
        end
    endtask

    task automatic test_ignored_start();
        int base, c0;
        bit ok;
        m_axis_tready = 1'b1;
        base = got_data.size();
        start_pass(7, 1'b0, c0);
        repeat (2) @(posedge aclk);
        #1;
        cfg_start = 1'b1;
        cfg_data  = 10'd2;
        @(posedge aclk); #1;
        cfg_start = 1'b0;
        wait_idle(40, ok);
        total++; if (!ok || got_data.size() !== base + 8) begin bad++; $display("FAIL ign_len: got %0d words want 8", got_data.size() - base); end
        for (int i = 0; i < 8 && base + i < got_data.size(); i++) begin
            total++;
            if (got_data[base+i] !== word_at(i) || got_last[base+i] !== (i == 7)) begin
                bad++; $display("FAIL ign_word%0d: data=%0d last=%b want %0d %b", i, got_data[base+i], got_last[base+i], word_at(i), (i == 7));
            end
        end
        base = got_data.size();
        @(posedge aclk); #1;
        cfg_start = 1'b1;
        @(posedge aclk); #1;
        cfg_start = 1'b0;
        wait_idle(40, ok);
        total++; if (!ok || got_data.size() !== base + 3) begin bad++; $display("FAIL ign_restart_len: got %0d words want 3", got_data.size() - base); end
        for (int i = 0; i < 3 && base + i < got_data.size(); i++) begin
            total++;
            if (got_data[base+i] !== word_at(i) || got_last[base+i] !== (i == 2)) begin
                bad++; $display("FAIL ign_restart_word%0d: data=%0d last=%b want %0d %b", i, got_data[base+i], got_last[base+i], word_at(i), (i == 2));
            end
        end
    endtask

    task automatic test_reset_midrun();
        int base, c0;
        m_axis_tready = 1'b0;
        base = got_data.size();
        start_pass(7, 1'b0, c0);
        repeat (4) @(posedge aclk);
        #1;
        total++; if (m_axis_tvalid !== 1'b1 || sts_busy !== 1'b1) begin bad++; $display("FAIL mid_prefill: tvalid=%b busy=%b want 1 1", m_axis_tvalid, sts_busy); end
        aresetn = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        total++; if (m_axis_tvalid !== 1'b0 || sts_busy !== 1'b0) begin bad++; $display("FAIL mid_flush: tvalid=%b busy=%b want 0 0", m_axis_tvalid, sts_busy); end
        m_axis_tready = 1'b1;
        repeat (10) @(posedge aclk);
        #1;
        total++; if (got_data.size() !== base) begin bad++; $display("FAIL mid_no_output: got %0d words want 0", got_data.size() - base); end
        total++; if (sts_data !== 10'd0 || b_bram_en !== 1'b0) begin bad++; $display("FAIL mid_idle: sts_data=%0d en=%b want 0 0", sts_data, b_bram_en); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i[9:0]] = (i < 16) ? 32'(i + 100) : $urandom;
        test_reset();
        test_single_pass();
        test_backpressure();
        test_continuous();
        test_edge_size();
        test_ignored_start();
        test_reset_midrun();
        test_random_size();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_bram_reader.md
# axis_bram_reader

Streams a block of words out of a BRAM over AXI4-Stream. It is the read-side companion of the stream-to-BRAM writer: a pass over addresses 0..cfg_data, either once or continuously. It hides the one-cycle BRAM read latency behind a 2-entry output buffer, so it sustains one word per cycle under full back-pressure compliance. Typical use is playback of a waveform table or readout of a captured record.

## Interface
- AXIS_TDATA_WIDTH, 32, stream data width; must equal BRAM_DATA_WIDTH.
- BRAM_DATA_WIDTH, 32, BRAM word width.
- BRAM_ADDR_WIDTH, 10, BRAM address width.

- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  reset, synchronous, active-low.
- cfg_data  in  BRAM_ADDR_WIDTH  last address of a pass (inclusive).
- cfg_cont  in  1  1 = wrap and repeat passes; 0 = stop after current pass.
- cfg_start  in  1  start pulse; honoured only in IDLE.
- sts_data  out  BRAM_ADDR_WIDTH  next read address to be issued.
- sts_busy  out  1  high in RUN and DRAIN.
- m_axis_tdata  out  AXIS_TDATA_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  marks the word read from the last address of a pass.
- b_bram_clk  out  1  = aclk.
- b_bram_rst  out  1  = ~aresetn.
- b_bram_en  out  1  read enable; one read per cycle when high.
- b_bram_addr  out  BRAM_ADDR_WIDTH  read address.
- b_bram_rdata  in  BRAM_DATA_WIDTH  read data, valid the cycle after b_bram_en.

## Operation
- States:
  - IDLE -> RUN on cfg_start. At that edge: latch cfg_data into end_reg and reset the address to 0.
  - RUN -> DRAIN when the read at end_reg is issued and cfg_cont is 0 at that edge.
  - DRAIN -> IDLE when the buffer is empty and no read is in flight.
- cfg_cont is sampled each time end_reg is issued. When it is 1, the address wraps to 0 and RUN continues. Clearing cfg_cont therefore ends the stream after the current pass completes.
- cfg_data is used only through end_reg. Changes to cfg_data mid-run have no effect until the next start.
- Read issue:
  - Condition: b_bram_en = RUN and (buf_count + inflight − pop) < 2, where pop = m_axis_tvalid & m_axis_tready.
  - b_bram_addr = current address.
  - On issue, the address increments, or wraps to 0 after end_reg.
- inflight is a 1-bit register set on issue. Data returning the following cycle is written into a 2-entry FIFO together with a last flag (address == end_reg at issue).
- Stream side:
  - m_axis_tvalid = buffer non-empty.
  - m_axis_tdata and m_axis_tlast come from the buffer head.
  - Once asserted, tvalid, tdata and tlast are held stable until accepted.
- Simultaneous push and pop on a 1-entry buffer leaves the count unchanged and the data order preserved.
- cfg_start outside IDLE is ignored.
- sts_data = current address register. It is 0 in IDLE after reset and holds its final value after a pass completes.

## Timing
- Reset (aresetn low at an edge): state IDLE, address 0, end_reg 0, buffer empty, inflight 0. All outputs are 0 (tvalid, tlast, tdata, b_bram_en, b_bram_addr, sts_data, sts_busy), except b_bram_rst, which is 1.
- Reset mid-operation flushes the buffer and any in-flight word. No word is emitted after reset deasserts without a new cfg_start.
- cfg_start sampled at edge n:
  - b_bram_en=1 with addr 0 during cycle n.
  - Data captured into the buffer at edge n+2.
  - m_axis_tvalid high from cycle n+2.
  - Startup latency is 2 cycles.
- With tready held high: one word per cycle, no bubbles, including across the wrap point in continuous mode.
- With tready low: at most 2 reads are outstanding or buffered, then b_bram_en drops. No word is lost or duplicated.
- cfg_data=0: every pass is a single word with tlast=1.
- sts_busy falls in the cycle after the last word is accepted.

## Test plan
- Single pass: BRAM[i]=i+100, cfg_data=7, cfg_cont=0, tready=1, start -> 8 words 100..107 on consecutive cycles starting 2 cycles after start; tlast only on 107; sts_busy low afterwards; sts_data=0.
- Back-pressure: same setup, tready toggling with a random ~50% duty -> output sequence identical to the single-pass case; tdata stable while tvalid&~tready; b_bram_en never issues a third outstanding read.
- Continuous: cfg_data=3, cfg_cont=1, tready=1 -> 0..3 repeating with no gaps, tlast on every 4th word; clear cfg_cont mid-pass -> stream ends after the current pass's tlast.
- Edge size: cfg_data=0, cfg_cont=1 -> the BRAM[0] word every cycle, each with tlast=1.
- Ignored start and config change: pulse cfg_start and change cfg_data to 2 during a cfg_data=7 pass -> the pass still outputs 8 words; a later start uses end address 2.
- Reset mid-run: assert aresetn low for one edge while tready=0 with 2 words buffered -> tvalid=0 and sts_busy=0 next cycle; no further output until a new start.
